// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline sequencer for the 4-stage 8-bit core. It decodes the instruction
//   held in the IF/ID register and produces the PC enable/load, the IF/ID
//   write-enable/flush and the ID/EX bubble request. It also sequences the
//   post-reset pipeline fill, the one-cycle RAW stall and external holds.
//
//   Instruction format: [7:6] op (00 MOV rd,rs / 01 ADD rd,rs / 10 NOP /
//   11 JMP addr[5:0]), [5:3] rd, [2:0] rs.
//
// Parameters
//   FILL_CYCLES  cycles after reset release before pipe_ready_o asserts
//   FWD_EN       1 = EX forwarding exists (no RAW stall), 0 = 1-cycle RAW stall
//   MAX_HOLD     ext_stall_i cycles tolerated in HOLD before hold_timeout_o
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   id_instr_i     instruction currently in the IF/ID register
//   ex_rd_i        destination register of the instruction in EX
//   ex_wr_en_i     EX instruction writes ex_rd_i
//   ext_stall_i    external hold request (memory/debug)
//   pc_en_o        PC increments this cycle
//   pc_load_o      PC loads pc_target_o this cycle
//   pc_target_o    jump target, id_instr_i[5:0]
//   if_id_en_o     IF/ID register captures a new instruction
//   if_id_flush_o  IF/ID register loads NOP (8'h80) on the next edge
//   id_ex_bubble_o ID/EX loads a bubble instead of the decoded instruction
//   pipe_ready_o   fill complete, pipeline valid
//   hold_timeout_o sticky: ext_stall_i held longer than MAX_HOLD
//   jump_count_o   saturating count of taken jumps
//   state_o        current FSM state (debug): 0 FILL, 1 RUN, 2 HAZ, 3 HOLD
//
// Handshake: there is no valid/ready pair here. pc_en_o/if_id_en_o are
//   qualifiers sampled by the PC and IF/ID register on the same rising edge;
//   every output is combinational from the registered state plus the current
//   inputs, and is forced to 0 while rst_ni is low.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int FILL_CYCLES = 3,
   parameter int FWD_EN      = 0,
   parameter int MAX_HOLD    = 15
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] id_instr_i,
   input  logic [2:0] ex_rd_i,
   input  logic       ex_wr_en_i,
   input  logic       ext_stall_i,
   output logic       pc_en_o,
   output logic       pc_load_o,
   output logic [5:0] pc_target_o,
   output logic       if_id_en_o,
   output logic       if_id_flush_o,
   output logic       id_ex_bubble_o,
   output logic       pipe_ready_o,
   output logic       hold_timeout_o,
   output logic [7:0] jump_count_o,
   output logic [1:0] state_o
);

   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HAZ  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [7:0] FILL_LAST = 8'(FILL_CYCLES - 1);
   localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b11;

   logic [1:0] state_q,    state_d;
   logic [7:0] fill_cnt_q, fill_cnt_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] jump_cnt_q, jump_cnt_d;
   logic       hold_to_q,  hold_to_d;

   // ---------------------------------------------------------------- decode
   logic [1:0] op;
   logic [2:0] rd;
   logic [2:0] rs;
   logic       is_jmp;
   logic       is_alu;
   logic       raw_hit;
   logic       hold_set;

   assign op     = id_instr_i[7:6];
   assign rd     = id_instr_i[5:3];
   assign rs     = id_instr_i[2:0];
   assign is_jmp = (op == OP_JMP);
   assign is_alu = (op == OP_MOV) || (op == OP_ADD);

   // MOV only reads rs; ADD reads both rd and rs.
   assign raw_hit = (FWD_EN == 0) && ex_wr_en_i && is_alu &&
                    ((ex_rd_i == rs) || ((op == OP_ADD) && (ex_rd_i == rd)));

   // Timeout condition in the current HOLD cycle; shown on the output in the
   // same cycle and latched into the sticky flag on the next edge.
   assign hold_set = (state_q == S_HOLD) && ext_stall_i && (hold_cnt_q == HOLD_MAX);

   // ------------------------------------------------------- state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_FILL;
         fill_cnt_q <= 8'd0;
         hold_cnt_q <= 8'd0;
         jump_cnt_q <= 8'd0;
         hold_to_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         jump_cnt_q <= jump_cnt_d;
         hold_to_q  <= hold_to_d;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      hold_cnt_d = hold_cnt_q;
      jump_cnt_d = jump_cnt_q;
      hold_to_d  = hold_to_q | hold_set;

      case (state_q)
         S_FILL: begin
            // ext_stall_i is deliberately ignored while the pipe fills.
            fill_cnt_d = fill_cnt_q + 8'd1;
            if (fill_cnt_q == FILL_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (ext_stall_i) begin
               state_d    = S_HOLD;
               hold_cnt_d = 8'd1;
            end else if (is_jmp) begin
               // Flushed slot decodes as NOP next cycle, so RUN continues.
               if (jump_cnt_q != 8'hFF) begin
                  jump_cnt_d = jump_cnt_q + 8'd1;
               end
            end else if (raw_hit) begin
               state_d = S_HAZ;
            end
         end
         S_HAZ: begin
            // The single stall cycle is already spent; RAW is not re-checked.
            if (ext_stall_i) begin
               state_d    = S_HOLD;
               hold_cnt_d = 8'd1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_HOLD: begin
            if (ext_stall_i) begin
               if (hold_cnt_q != 8'hFF) begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
            end else begin
               // Pending JMP/RAW is re-evaluated by RUN on the next cycle.
               state_d    = S_RUN;
               hold_cnt_d = 8'd0;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      pc_en_o        = 1'b0;
      pc_load_o      = 1'b0;
      pc_target_o    = 6'd0;
      if_id_en_o     = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      pipe_ready_o   = 1'b0;

      if (rst_ni) begin
         pc_target_o = id_instr_i[5:0];
         case (state_q)
            S_FILL: begin
               pc_en_o        = 1'b1;
               if_id_en_o     = 1'b1;
               id_ex_bubble_o = 1'b1;
            end
            S_RUN: begin
               pipe_ready_o = 1'b1;
               if (ext_stall_i) begin
                  id_ex_bubble_o = 1'b1;
               end else if (is_jmp) begin
                  pc_load_o     = 1'b1;
                  if_id_flush_o = 1'b1;
                  if_id_en_o    = 1'b1;
               end else if (raw_hit) begin
                  id_ex_bubble_o = 1'b1;
               end else begin
                  pc_en_o    = 1'b1;
                  if_id_en_o = 1'b1;
               end
            end
            S_HAZ: begin
               pipe_ready_o = 1'b1;
               if (ext_stall_i) begin
                  id_ex_bubble_o = 1'b1;
               end else begin
                  pc_en_o    = 1'b1;
                  if_id_en_o = 1'b1;
               end
            end
            S_HOLD: begin
               pipe_ready_o   = 1'b1;
               id_ex_bubble_o = 1'b1;
            end
            default: begin
               pipe_ready_o = 1'b0;
            end
         endcase
      end
   end

   assign hold_timeout_o = hold_to_q | (rst_ni & hold_set);
   assign jump_count_o   = jump_cnt_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl. A behavioural model tracks what the
//   sequencer must be doing (filling, holding, serving a RAW stall, counting
//   jumps) and is compared against every output on each falling edge.
//   Hand-computed literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int FILL     = 3;
   localparam int MAX_HOLD = 15;

   // ------------------------------------------------------ clock and reset
   logic       clk = 1'b0;
   logic       rst_ni;
   logic [7:0] id_instr;
   logic [2:0] ex_rd;
   logic       ex_wr_en;
   logic       ext_stall;

   logic       pc_en, pc_load, if_id_en, if_id_flush, id_ex_bubble;
   logic       pipe_ready, hold_timeout;
   logic [5:0] pc_target;
   logic [7:0] jump_count;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .FILL_CYCLES(FILL),
      .FWD_EN     (0),
      .MAX_HOLD   (MAX_HOLD)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .id_instr_i    (id_instr),
      .ex_rd_i       (ex_rd),
      .ex_wr_en_i    (ex_wr_en),
      .ext_stall_i   (ext_stall),
      .pc_en_o       (pc_en),
      .pc_load_o     (pc_load),
      .pc_target_o   (pc_target),
      .if_id_en_o    (if_id_en),
      .if_id_flush_o (if_id_flush),
      .id_ex_bubble_o(id_ex_bubble),
      .pipe_ready_o  (pipe_ready),
      .hold_timeout_o(hold_timeout),
      .jump_count_o  (jump_count),
      .state_o       (state_dbg)
   );

   // --------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // --------------------------------------------------- behavioural model
   int m_fill;    // cycles of fill completed since release
   bit m_hold;    // an external hold is in progress
   int m_hlen;    // length of current hold, counted from entry
   bit m_haz;     // the RAW stall cycle has just been taken
   int m_jumps;   // taken jumps, saturating
   bit m_tmo;     // sticky timeout already latched

   task automatic model_reset();
      m_fill  = 0;
      m_hold  = 0;
      m_hlen  = 0;
      m_haz   = 0;
      m_jumps = 0;
      m_tmo   = 0;
   endtask

   // Compare all outputs for the current cycle, then advance the model to
   // where it must be after the next rising edge.
   task automatic model_cycle();
      logic       e_pc_en, e_load, e_ifen, e_flush, e_bub, e_ready, e_tmo;
      logic [5:0] e_tgt;
      logic [1:0] op;
      bit         jmp, raw;

      op  = id_instr[7:6];
      jmp = (op == 2'b11);
      raw = ex_wr_en && (op == 2'b00 || op == 2'b01) &&
            (ex_rd == id_instr[2:0] || (op == 2'b01 && ex_rd == id_instr[5:3]));

      e_pc_en = 0; e_load = 0; e_ifen = 0; e_flush = 0; e_bub = 0; e_ready = 0;
      e_tgt   = 6'd0;

      if (!rst_ni) model_reset();
      e_tmo = m_tmo;

      if (rst_ni) begin
         e_tgt = id_instr[5:0];
         if (m_fill < FILL) begin
            e_pc_en = 1; e_ifen = 1; e_bub = 1;
         end else begin
            e_ready = 1;
            if (m_hold) begin
               e_bub = 1;
               if (ext_stall && m_hlen == MAX_HOLD) e_tmo = 1;
            end else if (ext_stall) begin
               e_bub = 1;
            end else if (m_haz) begin
               e_pc_en = 1; e_ifen = 1;
            end else if (jmp) begin
               e_load = 1; e_flush = 1; e_ifen = 1;
            end else if (raw) begin
               e_bub = 1;
            end else begin
               e_pc_en = 1; e_ifen = 1;
            end
         end
      end

      chk("pc_en",        32'(pc_en),        32'(e_pc_en));
      chk("pc_load",      32'(pc_load),      32'(e_load));
      chk("pc_target",    32'(pc_target),    32'(e_tgt));
      chk("if_id_en",     32'(if_id_en),     32'(e_ifen));
      chk("if_id_flush",  32'(if_id_flush),  32'(e_flush));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("pipe_ready",   32'(pipe_ready),   32'(e_ready));
      chk("hold_timeout", 32'(hold_timeout), 32'(e_tmo));
      chk("jump_count",   32'(jump_count),   32'(m_jumps));

      if (rst_ni) begin
         if (m_fill < FILL) begin
            m_fill++;
         end else if (m_hold) begin
            if (ext_stall) begin
               if (m_hlen == MAX_HOLD) m_tmo = 1;
               if (m_hlen < 255) m_hlen++;
            end else begin
               m_hold = 0;
               m_hlen = 0;
            end
         end else if (ext_stall) begin
            m_hold = 1;
            m_hlen = 1;
            m_haz  = 0;
         end else if (m_haz) begin
            m_haz = 0;
         end else if (jmp) begin
            if (m_jumps < 255) m_jumps++;
         end else if (raw) begin
            m_haz = 1;
         end
      end
   endtask

   // Compare on the falling edge, then return 1 time unit after the next
   // rising edge, where the driver changes inputs.
   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] instr, input logic [2:0] rd,
                        input logic wr, input logic stall);
      id_instr  = instr;
      ex_rd     = rd;
      ex_wr_en  = wr;
      ext_stall = stall;
   endtask

   // Directed RAW vectors: instr, ex_rd, ex_wr_en, stall expected.
   typedef struct packed {
      logic [7:0] instr;
      logic [2:0] rd;
      logic       wr;
      logic       stall;
   } raw_vec_t;

   raw_vec_t raw_tab [7];

   // ------------------------------------------------------------ stimulus
   initial begin
      raw_tab[0] = '{8'h4A, 3'd2, 1'b1, 1'b1}; // ADD r1,r2 : rs hit
      raw_tab[1] = '{8'h4A, 3'd1, 1'b1, 1'b1}; // ADD r1,r2 : rd hit
      raw_tab[2] = '{8'h0A, 3'd1, 1'b1, 1'b0}; // MOV r1,r2 : rd not a source
      raw_tab[3] = '{8'h0A, 3'd2, 1'b1, 1'b1}; // MOV r1,r2 : rs hit
      raw_tab[4] = '{8'h4A, 3'd2, 1'b0, 1'b0}; // EX does not write
      raw_tab[5] = '{8'h8A, 3'd2, 1'b1, 1'b0}; // NOP never stalls
      raw_tab[6] = '{8'h4A, 3'd3, 1'b1, 1'b0}; // no register match

      model_reset();
      rst_ni = 1'b0;
      drive(8'h80, 3'd0, 1'b0, 1'b0);
      #2;
      chk("reset_pc_en", 32'(pc_en), 32'd0);
      chk("reset_ifen",  32'(if_id_en), 32'd0);
      tick();
      tick();
      tick();

      // Fill: pipe_ready rises exactly FILL cycles after release.
      rst_ni = 1'b1;
      #1;
      chk("fill_ready_0", 32'(pipe_ready), 32'd0);
      chk("fill_pc_en",   32'(pc_en), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("fill_ready", 32'(pipe_ready), (k == 3) ? 32'd1 : 32'd0);
      end

      // JMP 5 in RUN.
      drive(8'hC5, 3'd0, 1'b0, 1'b0);
      #1;
      chk("jmp_load",   32'(pc_load), 32'd1);
      chk("jmp_target", 32'(pc_target), 32'd5);
      chk("jmp_flush",  32'(if_id_flush), 32'd1);
      chk("jmp_pc_en",  32'(pc_en), 32'd0);
      tick();
      chk("jmp_count1", 32'(jump_count), 32'd1);
      drive(8'h80, 3'd0, 1'b0, 1'b0);
      tick();

      // RAW table: one stall cycle then issue with the same instruction.
      for (int i = 0; i < 7; i++) begin
         drive(raw_tab[i].instr, raw_tab[i].rd, raw_tab[i].wr, 1'b0);
         #1;
         chk("raw_pc_en",  32'(pc_en), raw_tab[i].stall ? 32'd0 : 32'd1);
         chk("raw_bubble", 32'(id_ex_bubble), 32'(raw_tab[i].stall));
         tick();
         chk("raw_issue", 32'(pc_en), 32'd1);
         drive(8'h80, 3'd0, 1'b0, 1'b0);
         tick();
      end

      // ext_stall arriving in the HAZ cycle goes to HOLD.
      drive(8'h4A, 3'd2, 1'b1, 1'b0);
      tick();
      ext_stall = 1'b1;
      #1;
      chk("haz_stall_pc_en", 32'(pc_en), 32'd0);
      chk("haz_stall_bub",   32'(id_ex_bubble), 32'd1);
      tick();
      drive(8'h80, 3'd0, 1'b0, 1'b0);
      tick();
      tick();

      // ext_stall for 20 cycles: timeout visible in the 15th HOLD cycle.
      ext_stall = 1'b1;
      tick();
      for (int i = 1; i <= 19; i++) begin
         chk("hold_frozen", 32'(pc_en), 32'd0);
         chk("hold_timeout", 32'(hold_timeout), (i >= 15) ? 32'd1 : 32'd0);
         tick();
      end
      ext_stall = 1'b0;
      tick();
      tick();
      chk("timeout_sticky", 32'(hold_timeout), 32'd1);

      // ext_stall with a JMP and a matching EX write: HOLD wins.
      drive(8'hC3, 3'd3, 1'b1, 1'b1);
      #1;
      chk("combo_no_load", 32'(pc_load), 32'd0);
      tick();
      tick();
      ext_stall = 1'b0;
      tick();
      chk("combo_load",   32'(pc_load), 32'd1);
      chk("combo_target", 32'(pc_target), 32'd3);
      tick();
      drive(8'h80, 3'd0, 1'b0, 1'b0);
      chk("combo_count", 32'(jump_count), 32'd2);
      tick();
      tick();
      chk("combo_count_once", 32'(jump_count), 32'd2);

      // Back-to-back jumps saturate the counter.
      drive(8'hC1, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 260; i++) tick();
      chk("jump_sat", 32'(jump_count), 32'd255);
      drive(8'h80, 3'd0, 1'b0, 1'b0);
      tick();

      // Reset asserted mid-HOLD clears everything immediately.
      drive(8'hC5, 3'd0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      rst_ni = 1'b0;
      #1;
      chk("rst_pc_target", 32'(pc_target), 32'd0);
      chk("rst_bubble",    32'(id_ex_bubble), 32'd0);
      chk("rst_ready",     32'(pipe_ready), 32'd0);
      chk("rst_timeout",   32'(hold_timeout), 32'd0);
      chk("rst_jumps",     32'(jump_count), 32'd0);
      tick();
      tick();
      drive(8'h80, 3'd0, 1'b0, 1'b1);
      rst_ni = 1'b1;
      #1;
      chk("refill_pc_en", 32'(pc_en), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("refill_ready", 32'(pipe_ready), (k == 3) ? 32'd1 : 32'd0);
      end
      ext_stall = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
